vga_pixel_fetch_rgb888: RTL and testbench
=========================================

// Module: vga_pixel_fetch_rgb888
// PURPOSE
// Upstream pixel source for the RGB888 3x3 filter stages. Generates 640x480@60 VGA timing at 25 MHz,
// 2x-upscales the 320x240 RGB565 framebuffer, and issues read addresses to it. Converts the returned
// RGB565 data to RGB888. Delivers pixel_in, pixel_addr, vsync and active_area to the filters, all
// cycle-aligned to each other, plus hsync/vsync for the VGA connector.
// PARAMETERS
// H_ACTIVE 640  visible clocks per line;  H_FP 16; H_SYNC 96; H_BP 48   (line = 800 clocks)
// V_ACTIVE 480  visible lines per frame;  V_FP 10; V_SYNC 2;  V_BP 33   (frame = 525 lines)
// RAM_LAT  1    framebuffer read latency in clocks (legal 1..3)
// PORTS
// clk          in   1   25 MHz pixel clock
// rst_n        in   1   asynchronous active-low reset
// test_pattern in   1   1 = 8 vertical colour bars replace fb_data (sampled per pixel, stage 0)
// fb_addr      out  17  framebuffer read address {y[7:0], x[8:0]}
// fb_data      in   16  RGB565 read data, valid RAM_LAT clocks after fb_addr
// pixel_out    out  24  RGB888 pixel; 0 outside active area
// pixel_addr   out  17  {y[7:0], x[8:0]} of pixel_out, x 0..319, y 0..239
// active_area  out  1   pixel_out is a visible pixel
// hsync        out  1   active-low horizontal sync
// vsync        out  1   active-low vertical sync (rising edge = end of sync pulse, resets filter caches)
// frame_start  out  1   one-clock pulse coincident with output pixel (0,0)
// BEHAVIOUR
// - Stage 0 counters: h_cnt 0..799 increments every clk and wraps to 0, incrementing v_cnt.
//   v_cnt 0..524 wraps to 0. Origin (0,0) = first visible pixel.
// - Stage 0 signals: act0 = h_cnt<640 && v_cnt<480; src x = h_cnt>>1, src y = v_cnt>>1.
//   fb_addr = act0 ? {y[7:0],x[8:0]} : 0, registered. Each address is held 2 clocks; each source line is read on 2 lines.
// - hs0 low for h_cnt 656..751. vs0 low for v_cnt 490..491, full lines.
// - Sideband pipeline: act0, hs0, vs0, address and test-pattern select are delayed RAM_LAT clocks by a
//   shift register, then one conversion register. Output latency L = RAM_LAT+1 clocks from counter state;
//   all outputs change on the same edge.
// - Conversion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}, with R5=fb_data[15:11],
//   G6=fb_data[10:5], B5=fb_data[4:0].
// - Test pattern: bar = x[8:6] (0..4 across 320; bars 5..7 unused). Colours: white, yellow, cyan, green,
//   magenta = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF.
// - Blanking: pixel_out = 0 and pixel_addr = 0 whenever the delayed act is 0.
// - frame_start = 1 exactly when the output stage carries h=0, v=0 and act=1.
// - Reset (async assert, sync release): h_cnt = v_cnt = 0 and every pipeline stage is cleared to inactive
//   (act 0, hs 1, vs 1). Outputs are pixel_out 0, pixel_addr 0, fb_addr 0, active_area 0, hsync 1,
//   vsync 1, frame_start 0.
//   After release, the first output pixel (0,0) appears L clocks later. Reset mid-frame restarts at (0,0)
//   with no partial pixel emitted.
// - test_pattern toggling mid-line takes effect on the next fetched pixel. No glitch on sync outputs.
// TESTING
// 1 Release rst_n with RAM_LAT=1 and fb_data=16'hF800. At clk 0 after release: fb_addr=0.
//   At clk 2: pixel_out=FF0000, active_area=1, pixel_addr=0, frame_start=1 (one clock only).
// 2 Conversion: fb_data 07E0->00FF00, 001F->0000FF, 8410->848284, FFFF->FFFFFF, 0000->000000.
// 3 Line timing: active_area high exactly 640 clocks per line, hsync low exactly 96 clocks starting 16 clocks
//   after active_area falls. Line period 800 clocks. pixel_addr x steps 0,0,1,1,...,319,319.
// 4 Frame timing: vsync low exactly 1600 clocks, starting at line 490. Frame period 420000 clocks.
//   The last visible output has pixel_addr=122687 ({239,319}).
// 5 test_pattern=1: pixel_out=FFFFFF for x 0..63, 00FF00 for x 192..255, FF00FF for x 256..319.
//   fb_data is ignored.
// 6 Drop rst_n at h_cnt=300 of line 100: all outputs go to reset values immediately (before the next clk).
//   After release, the frame restarts at (0,0). Repeat the same check with RAM_LAT=3 (L=4).

Source files
------------

// File: rtl/vga_pixel_fetch_rgb888.sv
// VGA 640x480@60 timing generator with 2x-upscaled RGB565 framebuffer fetch and RGB888 output.
// Sideband (act/sync/address/pattern select) is delayed to line up with the returning read data.
module vga_pixel_fetch_rgb888 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RAM_LAT  = 1   // legal 1..3; the fb_addr register counts as the first clock
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        test_pattern,
  output logic [16:0] fb_addr,
  input  logic [15:0] fb_data,
  output logic [23:0] pixel_out,
  output logic [16:0] pixel_addr,
  output logic        active_area,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SBW     = 22;
  // Sideband word: {first, tp, vs, hs, act, addr[16:0]}; idle = inactive with syncs deasserted.
  localparam logic [SBW-1:0] SB_IDLE = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0};

  logic [HW-1:0]  r_h_cnt;
  logic [VW-1:0]  r_v_cnt;
  logic           w_act0;
  logic           w_hs0;
  logic           w_vs0;
  logic           w_first0;
  logic [8:0]     w_x0;
  logic [7:0]     w_y0;
  logic [16:0]    w_addr0;
  logic [SBW-1:0] w_sb0;
  logic [SBW-1:0] r_sb [0:RAM_LAT-1];
  logic [SBW-1:0] w_sb_d;
  logic           w_act_d;
  logic [23:0]    w_bar_rgb;
  logic [23:0]    w_conv_rgb;
  logic [23:0]    w_pix_d;
  logic [16:0]    r_fb_addr;
  logic [23:0]    r_pixel;
  logic [16:0]    r_pixel_addr;
  logic           r_act;
  logic           r_hs;
  logic           r_vs;
  logic           r_fs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == HW'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign w_act0   = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs0    = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) && (r_h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs0    = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) && (r_v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_first0 = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_x0     = 9'(r_h_cnt >> 1);
  assign w_y0     = 8'(r_v_cnt >> 1);
  assign w_addr0  = w_act0 ? {w_y0, w_x0} : 17'd0;
  assign w_sb0    = {w_first0 & w_act0, test_pattern, w_vs0, w_hs0, w_act0, w_addr0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_addr <= 17'd0;
      for (int i = 0; i < RAM_LAT; i++) r_sb[i] <= SB_IDLE;
    end else begin
      r_fb_addr <= w_addr0;
      r_sb[0]   <= w_sb0;
      for (int i = 1; i < RAM_LAT; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  // The last sideband stage is aligned with fb_data for the same pixel.
  assign w_sb_d  = r_sb[RAM_LAT-1];
  assign w_act_d = w_sb_d[17];

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_sb_d[8:6])
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  assign w_conv_rgb = {fb_data[15:11], fb_data[15:13],
                       fb_data[10:5],  fb_data[10:9],
                       fb_data[4:0],   fb_data[4:2]};
  assign w_pix_d    = !w_act_d ? 24'h000000 : (w_sb_d[20] ? w_bar_rgb : w_conv_rgb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel      <= 24'h000000;
      r_pixel_addr <= 17'd0;
      r_act        <= 1'b0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_fs         <= 1'b0;
    end else begin
      r_pixel      <= w_pix_d;
      r_pixel_addr <= w_act_d ? w_sb_d[16:0] : 17'd0;
      r_act        <= w_act_d;
      r_hs         <= w_sb_d[18];
      r_vs         <= w_sb_d[19];
      r_fs         <= w_sb_d[21] & w_act_d;
    end
  end

  assign fb_addr     = r_fb_addr;
  assign pixel_out   = r_pixel;
  assign pixel_addr  = r_pixel_addr;
  assign active_area = r_act;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_pixel_fetch_rgb888.sv
// Bench for vga_pixel_fetch_rgb888: two instances (RAM_LAT 1 and 3) share stimulus and are checked
// every cycle against a frame-position model; the vertical frame is shortened to keep runs short.
module tb_vga_pixel_fetch_rgb888;

  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACTIVE = 8,   V_FP = 2,  V_SYNC = 2,  V_BP = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [23:0] pix;
    logic [16:0] paddr;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
  } out_t;

  typedef struct { logic [15:0] d; logic [23:0] exp; } conv_vec_t;
  typedef struct { int x; logic [23:0] exp; } tp_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        test_pattern;
  logic        force_en;
  logic [15:0] force_val;
  logic [15:0] mem [0:131071];

  logic [16:0] fb_addr_a, fb_addr_b, paddr_a, paddr_b, b_addr_d1, b_addr_d2;
  logic [15:0] fb_data_a, fb_data_b;
  logic [23:0] pix_a, pix_b;
  logic        act_a, hs_a, vs_a, fs_a, act_b, hs_b, vs_b, fs_b;

  // Framebuffer models: latency 1 reads straight from fb_addr, latency 3 adds two address registers.
  assign fb_data_a = force_en ? force_val : mem[fb_addr_a];
  always @(posedge clk) begin
    b_addr_d1 <= fb_addr_b;
    b_addr_d2 <= b_addr_d1;
  end
  assign fb_data_b = force_en ? force_val : mem[b_addr_d2];

  vga_pixel_fetch_rgb888 #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RAM_LAT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .test_pattern(test_pattern), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
    .pixel_out(pix_a), .pixel_addr(paddr_a), .active_area(act_a), .hsync(hs_a), .vsync(vs_a),
    .frame_start(fs_a)
  );

  vga_pixel_fetch_rgb888 #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RAM_LAT(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .test_pattern(test_pattern), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
    .pixel_out(pix_b), .pixel_addr(paddr_b), .active_area(act_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit tp_hist [int];

  // Line/frame statistics measured on the latency-1 instance.
  int prev_act, prev_hs, prev_vs;
  int act_len, last_act_len, act_fall_cyc, hs_len, last_hs_len, hs_fall_gap;
  int vs_len, last_vs_len, vs_fall_ofs, last_fs_cyc, fs_period, fs_count;
  logic [16:0] last_act_paddr, vs_last_paddr;

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
  endtask

  task automatic check_val(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, actual, expected);
      if (fails >= 40) begin
        report();
        $finish;
      end
    end
  endtask

  function automatic logic [23:0] conv565(input logic [15:0] d);
    int r5, g6, b5;
    r5 = int'(d) / 2048;
    g6 = (int'(d) / 32) % 64;
    b5 = int'(d) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  function automatic logic [23:0] bar_colour(input int x);
    case (x / 64)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Output expected for counter position n (cycles since reset release); n < 0 means still idle.
  function automatic out_t model_out(input int n);
    out_t o;
    int h, v, x, y;
    o.pix = 24'h0; o.paddr = 17'h0; o.act = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0;
    if (n < 0) return o;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    o.hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    o.vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    if (h < H_ACTIVE && v < V_ACTIVE) begin
      x = h / 2;
      y = v / 2;
      o.act   = 1'b1;
      o.paddr = 17'(y * 512 + x);
      o.pix   = tp_hist[n] ? bar_colour(x) : conv565(force_en ? force_val : mem[y * 512 + x]);
      o.fs    = (h == 0 && v == 0);
    end
    return o;
  endfunction

  function automatic logic [16:0] model_fb_addr(input int n);
    out_t o;
    o = model_out(n);
    return o.paddr;
  endfunction

  task automatic reset_stats();
    prev_act = 0; prev_hs = 1; prev_vs = 1;
    act_len = 0; last_act_len = -1; act_fall_cyc = -100000; hs_len = 0; last_hs_len = -1;
    hs_fall_gap = -1; vs_len = 0; last_vs_len = -1; vs_fall_ofs = -1; last_fs_cyc = -1;
    fs_period = -1; fs_count = 0; last_act_paddr = '0; vs_last_paddr = '0;
  endtask

  task automatic update_stats();
    if (act_a) begin
      act_len++;
      last_act_paddr = paddr_a;
    end
    if (prev_act == 1 && !act_a) begin
      last_act_len = act_len;
      act_len = 0;
      act_fall_cyc = cyc;
    end
    if (!hs_a) hs_len++;
    if (prev_hs == 1 && !hs_a && (cyc - act_fall_cyc) < H_TOTAL) hs_fall_gap = cyc - act_fall_cyc;
    if (prev_hs == 0 && hs_a) begin
      last_hs_len = hs_len;
      hs_len = 0;
    end
    if (!vs_a) vs_len++;
    if (prev_vs == 1 && !vs_a) begin
      vs_fall_ofs = cyc - last_fs_cyc;
      vs_last_paddr = last_act_paddr;
    end
    if (prev_vs == 0 && vs_a) begin
      last_vs_len = vs_len;
      vs_len = 0;
    end
    if (fs_a) begin
      fs_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
      fs_count++;
    end
    prev_act = int'(act_a); prev_hs = int'(hs_a); prev_vs = int'(vs_a);
  endtask

  task automatic check_outputs();
    out_t got;
    got = {pix_a, paddr_a, act_a, hs_a, vs_a, fs_a};
    check_val("out_lat1", 64'(got), 64'(model_out(cyc - 2)));
    got = {pix_b, paddr_b, act_b, hs_b, vs_b, fs_b};
    check_val("out_lat3", 64'(got), 64'(model_out(cyc - 4)));
    check_val("fb_addr_lat1", 64'(fb_addr_a), 64'(model_fb_addr(cyc - 1)));
    check_val("fb_addr_lat3", 64'(fb_addr_b), 64'(model_fb_addr(cyc - 1)));
  endtask

  // Inputs set before calling tick are the ones seen by the counter state of the current cycle.
  task automatic tick();
    tp_hist[cyc] = test_pattern;
    @(posedge clk);
    if (rst_n) cyc++;
    @(negedge clk);
    update_stats();
    check_outputs();
  endtask

  task automatic restart(input logic fe, input logic [15:0] fv, input logic tp);
    rst_n = 1'b0;
    cyc = 0;
    tp_hist.delete();
    tick();
    force_en = fe;
    force_val = fv;
    test_pattern = tp;
    reset_stats();
    tick();
    rst_n = 1'b1;
  endtask

  conv_vec_t cv [5];
  tp_vec_t   tv [8];

  initial begin
    cv[0] = '{16'h07E0, 24'h00FF00};
    cv[1] = '{16'h001F, 24'h0000FF};
    cv[2] = '{16'h8410, 24'h848284};
    cv[3] = '{16'hFFFF, 24'hFFFFFF};
    cv[4] = '{16'h0000, 24'h000000};
    tv[0] = '{0,   24'hFFFFFF};
    tv[1] = '{63,  24'hFFFFFF};
    tv[2] = '{64,  24'hFFFF00};
    tv[3] = '{128, 24'h00FFFF};
    tv[4] = '{192, 24'h00FF00};
    tv[5] = '{255, 24'h00FF00};
    tv[6] = '{256, 24'hFF00FF};
    tv[7] = '{319, 24'hFF00FF};

    for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0;
    test_pattern = 1'b0;
    force_en = 1'b1;
    force_val = 16'hF800;
    reset_stats();
    @(negedge clk);
    tick();
    check_val("rst_pixel_out", 64'(pix_a), 64'h0);
    check_val("rst_hsync_vsync", 64'({hs_a, vs_a, hs_b, vs_b}), 64'hF);
    check_val("rst_act_fs", 64'({act_a, fs_a, act_b, fs_b}), 64'h0);

    // First pixel after release: fb_data = F800 gives pure red at clock L.
    rst_n = 1'b1;
    #1;
    check_val("rel_fb_addr_clk0", 64'(fb_addr_a), 64'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (cyc == 2) begin
        check_val("first_pix_lat1", 64'({pix_a, act_a, paddr_a, fs_a}), 64'({24'hFF0000, 1'b1, 17'd0, 1'b1}));
      end
      if (cyc == 3) check_val("fs_one_clock_lat1", 64'(fs_a), 64'h0);
      if (cyc == 4) begin
        check_val("first_pix_lat3", 64'({pix_b, act_b, paddr_b, fs_b}), 64'({24'hFF0000, 1'b1, 17'd0, 1'b1}));
      end
    end

    for (int v = 0; v < 5; v++) begin
      restart(1'b1, cv[v].d, 1'b0);
      for (int i = 1; i <= 4; i++) begin
        tick();
        if (cyc == 2) check_val($sformatf("conv_lat1_%04h", cv[v].d), 64'(pix_a), 64'(cv[v].exp));
        if (cyc == 4) check_val($sformatf("conv_lat3_%04h", cv[v].d), 64'(pix_b), 64'(cv[v].exp));
      end
    end

    // Colour bars over line 0 with random framebuffer contents behind them.
    restart(1'b0, 16'h0, 1'b1);
    for (int v = 0; v < 8; v++) begin
      while (cyc < 2 * tv[v].x + 2) tick();
      check_val($sformatf("bar_x%0d", tv[v].x), 64'(pix_a), 64'(tv[v].exp));
    end

    // Randomized run over two full frames with test_pattern toggling mid-line.
    restart(1'b0, 16'h0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2 * FRAME + 2000; i++) begin
      if ($urandom_range(0, 149) == 0) test_pattern = ~test_pattern;
      tick();
    end
    check_val("act_len_per_line", 64'(last_act_len), 64'(H_ACTIVE));
    check_val("hsync_low_len", 64'(last_hs_len), 64'(H_SYNC));
    check_val("hsync_after_act_fall", 64'(hs_fall_gap), 64'(H_FP));
    check_val("vsync_low_len", 64'(last_vs_len), 64'(V_SYNC * H_TOTAL));
    check_val("vsync_start_line", 64'(vs_fall_ofs), 64'((V_ACTIVE + V_FP) * H_TOTAL));
    check_val("frame_period", 64'(fs_period), 64'(FRAME));
    check_val("frame_count", 64'(fs_count), 64'(3));
    check_val("last_visible_addr", 64'(vs_last_paddr), 64'({8'(V_ACTIVE / 2 - 1), 9'd319}));

    // Reset asserted mid-line: outputs fall back before the next clock, then the frame restarts.
    restart(1'b0, 16'h0, 1'b0);
    while (cyc < 5 * H_TOTAL + 300) begin
      if ($urandom_range(0, 99) == 0) test_pattern = ~test_pattern;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_lat1", 64'({pix_a, paddr_a, fb_addr_a, act_a, hs_a, vs_a, fs_a}), 64'({24'h0, 17'h0, 17'h0, 4'b0110}));
    check_val("midrst_lat3", 64'({pix_b, paddr_b, fb_addr_b, act_b, hs_b, vs_b, fs_b}), 64'({24'h0, 17'h0, 17'h0, 4'b0110}));
    cyc = 0;
    tp_hist.delete();
    reset_stats();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) test_pattern = ~test_pattern;
      tick();
      if (cyc == 2) check_val("restart_fs_lat1", 64'({fs_a, paddr_a}), 64'({1'b1, 17'd0}));
      if (cyc == 4) check_val("restart_fs_lat3", 64'({fs_b, paddr_b}), 64'({1'b1, 17'd0}));
    end

    report();
    $finish;
  end

endmodule
